serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: the inverse datapath to the ripple-carry adder.
- Accepts operands a and b through a valid/ready handshake and computes a - b one bit per clock, LSB first.
- Returns the difference and a borrow flag through a second valid/ready handshake.
- Serves as the area-cheap subtract path in the SoC arithmetic block and as a cross-check for the adder: a + b - b == a.

Parameters:
- WIDTH, default DATA_WIDTH (from soc_pkg): operand and result width in bits. Must be >= 2.

Ports:
- clk        input   1      system clock, rising edge
- rst        input   1      synchronous, active-high reset
- in_valid   input   1      operands a and b are valid
- in_ready   output  1      block can accept operands
- a          input   WIDTH  minuend (data_t)
- b          input   WIDTH  subtrahend (data_t)
- out_valid  output  1      diff and borrowOut are valid
- out_ready  input   1      consumer accepts the result
- diff       output  WIDTH  (a - b) mod 2^WIDTH
- borrowOut  output  1      1 iff a < b (unsigned)
- busy       output  1      high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, borrowOut=0, busy=0. Internal shift registers, borrow register and bit counter are all 0.
- State machine: IDLE, SHIFT, DONE (sub_state_t).
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&&in_ready: load a_sr<=a, b_sr<=b, br<=0, cnt<=0, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, a full-subtractor cell computes d = a_sr[0]^b_sr[0]^br and bn = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&br).
  - a_sr and b_sr shift right by 1. d shifts into res_sr at the MSB. br<=bn. cnt++.
  - When cnt==WIDTH-1 on this edge: go to DONE, diff<=final res_sr, borrowOut<=bn.
- DONE:
  - out_valid=1. diff and borrowOut are held stable until out_ready is sampled high.
  - On out_valid&&out_ready: go to IDLE, out_valid<=0.
  - diff keeps its last value (do not clear it).
- Latency: if operands are accepted at edge E0, out_valid is first high in the cycle after edge E0+WIDTH. That is exactly WIDTH SHIFT cycles.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH shifts, result handshake).
- No combinational path from any input to any output. in_ready, out_valid and busy are decoded from registered state only.
- in_valid in SHIFT or DONE is ignored; operands are not queued. a and b only need to be stable on the accepting edge.
- out_ready in IDLE or SHIFT is ignored.
- Back-to-back: in_ready rises in the cycle after the result handshake, never in the same cycle.
- Reset mid-operation: rst in any state forces IDLE and the reset values on that edge. The partial result is discarded and no out_valid pulse is produced.
- rst dominates a simultaneous handshake.
- Arithmetic: unsigned modulo-2^WIDTH. borrowOut is the final borrow, so {borrowOut,diff} == {1'b0,a} - {1'b0,b} taken modulo 2^(WIDTH+1).

Decomposition:
- soc_pkg holds DATA_WIDTH, data_t, the new enum sub_state_t {IDLE, SHIFT, DONE}, and localparam CNT_W = $clog2(DATA_WIDTH).
- One combinational sub-module: full_subtractor (inputs a, b, bin; outputs d, bout). Instantiated once in serial_subtractor.

Test Plan (WIDTH=8):
- Basic: a=200, b=55, out_ready=1 -> after exactly 8 SHIFT cycles, out_valid=1, diff=145, borrowOut=0.
- Borrow/wrap: a=0, b=1 -> diff=255, borrowOut=1. Also a=55, b=200 -> diff=111, borrowOut=1.
- Edges: a=b=170 -> diff=0, borrowOut=0. a=255, b=0 -> diff=255, borrowOut=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> diff and out_valid stay stable, in_ready=0, and a new in_valid is ignored. Then raise out_ready -> result is consumed, in_ready=1 on the next cycle.
- Reset mid-op: assert rst at SHIFT cycle 3 -> next cycle state=IDLE, in_ready=1, out_valid=0, diff=0, and no result appears afterwards.
- Random: 200 handshaked random pairs, with out_ready randomly stalled -> each result equals (a-b) mod 256 and borrow equals (a<b). Also chain with ripplecarry_adder: feed (a+b mod 256, b) and require diff==a.

Source files
------------

// File: rtl/soc_pkg.sv
// soc_pkg: shared SoC arithmetic-block definitions.
//   DATA_WIDTH  - default datapath width
//   data_t      - one datapath word
//   sub_state_t - serial subtractor control states
//   CNT_W       - bit-counter width for a DATA_WIDTH-bit serial operation
package soc_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

endpackage : soc_pkg

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit full subtractor cell, purely combinational.
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow in
//   d    - difference bit  (a - b - bin) mod 2
//   bout - borrow out      (a < b + bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic axb;

  always_comb begin
    axb  = a ^ b;
    d    = axb ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    bout = (~a & b) | (~axb & bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first.
// Operands are accepted on an in_valid/in_ready handshake, WIDTH clock
// cycles are spent shifting through a single full-subtractor cell, then the
// result is offered on an out_valid/out_ready handshake.
//   clk, rst      - clock and synchronous active-high reset
//   in_valid/in_ready, a, b          - operand handshake (a - b)
//   out_valid/out_ready, diff, borrowOut - result handshake
//   busy          - high while an operation is in flight (SHIFT or DONE)
module serial_subtractor
  import soc_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut,
  output logic             busy
);

  // Counter sized for this instance; matches CNT_W at the default width.
  localparam int unsigned        CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    last_bit = (cnt_q == CNT_LAST);
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          res_sr_d = '0;
          br_d     = 1'b0;
          cnt_d    = '0;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = {cell_d, res_sr_q[WIDTH-1:1]};
        br_d     = cell_bout;
        cnt_d    = cnt_q + 1'b1;
        if (last_bit) begin
          // Publish the fully shifted result, including this cycle's bit.
          diff_d   = {cell_d, res_sr_q[WIDTH-1:1]};
          borrow_d = cell_bout;
          cnt_d    = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    diff      = diff_q;
    borrowOut = borrow_q;
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrowOut;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrowOut (borrowOut),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'(x) - int'(y);
    if (r < 0) r = r + 256;
    return r[W-1:0];
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  // Drives one operation: accept, wait for result (bounded), stall out_ready
  // for 'stall' cycles, then complete the result handshake.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input int stall,
                        output logic [W-1:0] d0, output logic bo0,
                        output logic [W-1:0] d1, output logic bo1,
                        output int lat, output bit ok);
    int guard;
    ok = 1'b1;
    guard = 0;
    out_ready = 1'b0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) ok = 1'b0;
    a = ta; b = tbv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) ok = 1'b0;
    d0 = diff; bo0 = borrowOut;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    d1 = diff; bo1 = borrowOut;
    if (!out_valid) ok = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy, borrowOut, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset: got in_ready=%b out_valid=%b busy=%b borrow=%b diff=%0d, want 1 0 0 0 0",
               in_ready, out_valid, busy, borrowOut, diff);
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0] va [5] = '{8'd200, 8'd0, 8'd55,  8'd170, 8'd255};
    logic [W-1:0] vb [5] = '{8'd55,  8'd1, 8'd200, 8'd170, 8'd0};
    logic [W-1:0] ed [5] = '{8'd145, 8'd255, 8'd111, 8'd0, 8'd255};
    logic         eb [5] = '{1'b0,   1'b1,   1'b1,   1'b0, 1'b0};
    logic [W-1:0] d0, d1;
    logic bo0, bo1;
    int lat;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], 0, d0, bo0, d1, bo1, lat, ok);
      n_checks++;
      if (!ok || lat != W) begin
        n_fail++;
        $display("FAIL latency[%0d]: got ok=%0b lat=%0d, want ok=1 lat=%0d", i, ok, lat, W);
      end
      n_checks++;
      if (d0 !== ed[i] || bo0 !== eb[i]) begin
        n_fail++;
        $display("FAIL vector[%0d] %0d-%0d: got diff=%0d borrow=%b, want diff=%0d borrow=%b",
                 i, va[i], vb[i], d0, bo0, ed[i], eb[i]);
      end
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL after_handshake[%0d]: got in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    a = 8'd100; b = 8'd30; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL bp_timeout: got out_valid=%b after %0d cycles, want 1", out_valid, lat);
    end
    for (int i = 0; i < 5; i++) begin
      a = 8'd9; b = 8'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, busy, borrowOut, diff} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'd70}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b busy=%b borrow=%b diff=%0d, want 1 0 1 0 70",
                 i, out_valid, in_ready, busy, borrowOut, diff);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    // The operands offered during DONE must not have started an operation.
    begin
      bit seen = 1'b0;
      repeat (12) begin
        @(posedge clk); #1;
        if (out_valid || busy) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
        n_fail++;
        $display("FAIL bp_ignored_input: got spurious operation=1, want 0");
      end
    end
  endtask

  task automatic test_reset_midop;
    bit seen = 1'b0;
    a = 8'd77; b = 8'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy !== 1'b1 || diff === 8'd0) begin
      n_fail++;
      $display("FAIL midop_pre: got busy=%b diff=%0d, want busy=1 diff!=0", busy, diff);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy, borrowOut, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL midop_reset: got in_ready=%b out_valid=%b busy=%b borrow=%b diff=%0d, want 1 0 0 0 0",
               in_ready, out_valid, busy, borrowOut, diff);
    end
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL midop_no_result: got out_valid pulse=1, want 0");
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ta, tbv, x, d0, d1, ed;
    logic bo0, bo1, eb;
    int lat;
    bit ok;
    bit chain;
    for (int i = 0; i < 200; i++) begin
      chain = (i % 2) == 1;
      x   = W'($urandom);
      tbv = W'($urandom);
      if (i < 4) tbv = (i == 0) ? 8'd0 : (i == 1) ? 8'd255 : x;
      // Chained mode models an adder feeding the subtractor: (x+b mod 256) - b == x.
      ta  = chain ? W'((int'(x) + int'(tbv)) % 256) : x;
      ed  = chain ? x : ref_diff(ta, tbv);
      eb  = ref_borrow(ta, tbv);
      run_op(ta, tbv, $urandom_range(0, 3), d0, bo0, d1, bo1, lat, ok);
      n_checks++;
      if (!ok || lat != W) begin
        n_fail++;
        $display("FAIL rand_handshake[%0d]: got ok=%0b lat=%0d, want ok=1 lat=%0d", i, ok, lat, W);
      end
      n_checks++;
      if (d0 !== ed || bo0 !== eb) begin
        n_fail++;
        $display("FAIL rand_result[%0d] %0d-%0d chain=%0b: got diff=%0d borrow=%b, want diff=%0d borrow=%b",
                 i, ta, tbv, chain, d0, bo0, ed, eb);
      end
      n_checks++;
      if (d1 !== d0 || bo1 !== bo0) begin
        n_fail++;
        $display("FAIL rand_stall_hold[%0d]: got diff=%0d borrow=%b, want diff=%0d borrow=%b",
                 i, d1, bo1, d0, bo0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor
